// File: rtl/ps2_pkg.sv
// Shared constants, state encoding and event layout
// for the PS/2 Set-2 scan code decoder.
package ps2_pkg;

  localparam logic [7:0] PREFIX_EXT   = 8'hE0;
  localparam logic [7:0] PREFIX_BRK   = 8'hF0;
  localparam logic [7:0] PREFIX_PAUSE = 8'hE1;
  localparam logic [7:0] ACK          = 8'hFA;
  localparam logic [7:0] RESEND       = 8'hFE;
  localparam logic [7:0] ECHO         = 8'hEE;
  localparam logic [7:0] BAT_OK       = 8'hAA;
  localparam logic [7:0] BAT_FAIL     = 8'hFC;
  localparam logic [7:0] OVR0         = 8'h00;
  localparam logic [7:0] OVR1         = 8'hFF;

  localparam logic [7:0] MOD_LSHIFT = 8'h12;
  localparam logic [7:0] MOD_RSHIFT = 8'h59;
  localparam logic [7:0] MOD_CTRL   = 8'h14;
  localparam logic [7:0] MOD_ALT    = 8'h11;
  localparam logic [7:0] PAUSE_CODE = 8'h77;

  localparam logic [2:0] PAUSE_LEN = 3'd7;
  localparam int         EVT_W     = 13;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_EXT_BRK,
    S_PAUSE
  } ps2_state_e;

  typedef struct packed {
    logic [2:0] mods;
    logic       brk;
    logic       ext;
    logic [7:0] code;
  } ps2_evt_t;

  function automatic logic is_status(
    input logic [7:0] b
  );
    return (b == ACK) || (b == RESEND) ||
           (b == ECHO) || (b == BAT_OK);
  endfunction

  function automatic logic is_fault(
    input logic [7:0] b
  );
    return (b == BAT_FAIL) || (b == OVR0) ||
           (b == OVR1);
  endfunction

  function automatic logic is_special(
    input logic [7:0] b
  );
    return (b == PREFIX_EXT) ||
           (b == PREFIX_BRK) ||
           (b == PREFIX_PAUSE) ||
           is_status(b) || is_fault(b);
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Synchronous event FIFO; a push into a full FIFO
// is accepted when a pop happens in the same cycle.
module ps2_event_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 13
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_cnt;
  logic          w_pop;
  logic          w_push;

  assign o_full  = (r_cnt == (AW+1)'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_data  = r_mem[r_rd];
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
      for (int i = 0; i < DEPTH; i++)
        r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= i_data;
        r_wr        <= r_wr + 1'b1;
      end
      if (w_pop)
        r_rd <= r_rd + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// Set-2 scan code sequence decoder with modifier
// tracking and a buffered valid/ready event output.
module ps2_scancode_decoder #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] received_data,
  input  logic       received_data_en,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [7:0] evt_code,
  output logic       evt_ext,
  output logic       evt_break,
  output logic [2:0] evt_mods,
  output logic       overflow,
  output logic       seq_error
);

  import ps2_pkg::*;

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  ps2_state_e    r_state;
  ps2_state_e    w_state_n;
  logic [2:0]    r_pcnt;
  logic [2:0]    w_pcnt_n;
  logic [TW-1:0] r_tmo;
  logic          r_seq_err;
  logic          r_ovf;
  logic [5:0]    r_mod;
  logic [5:0]    w_mod_n;
  logic [7:0]    w_b;
  logic [2:0]    w_mods;
  ps2_evt_t      w_evt;
  ps2_evt_t      w_head;
  logic          w_emit;
  logic          w_err;
  logic          w_fake;
  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic          w_tmo_hit;

  assign w_b = received_data;

  // r_mod = {ralt, lalt, rctrl, lctrl, rshift, lshift}
  assign w_mods = {r_mod[5] | r_mod[4],
                   r_mod[3] | r_mod[2],
                   r_mod[1] | r_mod[0]};

  assign w_tmo_hit = (r_state != S_IDLE) &&
                     (r_tmo == TW'(TIMEOUT_CYCLES));

  always_comb begin
    w_state_n = r_state;
    w_pcnt_n  = r_pcnt;
    w_emit    = 1'b0;
    w_err     = 1'b0;
    w_evt     = '0;
    w_evt.mods = w_mods;
    w_evt.code = w_b;
    if (received_data_en) begin
      unique case (r_state)
        S_IDLE: begin
          unique case (1'b1)
            (w_b == PREFIX_EXT):
              w_state_n = S_EXT;
            (w_b == PREFIX_BRK):
              w_state_n = S_BRK;
            (w_b == PREFIX_PAUSE): begin
              w_state_n = S_PAUSE;
              w_pcnt_n  = PAUSE_LEN;
            end
            is_status(w_b): ;
            is_fault(w_b):
              w_err = 1'b1;
            default:
              w_emit = 1'b1;
          endcase
        end
        S_EXT: begin
          if (w_b == PREFIX_BRK) begin
            w_state_n = S_EXT_BRK;
          end else begin
            w_state_n = S_IDLE;
            w_err     = is_special(w_b);
            w_emit    = !is_special(w_b);
            w_evt.ext = 1'b1;
          end
        end
        S_BRK, S_EXT_BRK: begin
          w_state_n = S_IDLE;
          w_err     = is_special(w_b);
          w_emit    = !is_special(w_b);
          w_evt.ext = (r_state == S_EXT_BRK);
          w_evt.brk = 1'b1;
        end
        S_PAUSE: begin
          w_pcnt_n = r_pcnt - 3'd1;
          if (r_pcnt == 3'd1) begin
            w_state_n  = S_IDLE;
            w_emit     = 1'b1;
            w_evt.ext  = 1'b1;
            w_evt.code = PAUSE_CODE;
          end
        end
        default: w_state_n = S_IDLE;
      endcase
    end else if (w_tmo_hit) begin
      w_state_n = S_IDLE;
      w_pcnt_n  = '0;
      w_err     = 1'b1;
    end
  end

  // E0 12 / E0 59 are keyboard-generated fake shifts
  assign w_fake = w_evt.ext &&
                  ((w_evt.code == MOD_LSHIFT) ||
                   (w_evt.code == MOD_RSHIFT));
  assign w_push = w_emit && !w_fake;
  assign w_pop  = evt_valid && evt_ready;

  always_comb begin
    w_mod_n = r_mod;
    if (w_push) begin
      if (!w_evt.ext && w_evt.code == MOD_LSHIFT)
        w_mod_n[0] = !w_evt.brk;
      if (!w_evt.ext && w_evt.code == MOD_RSHIFT)
        w_mod_n[1] = !w_evt.brk;
      if (w_evt.code == MOD_CTRL)
        w_mod_n[{2'b01, w_evt.ext}] = !w_evt.brk;
      if (w_evt.code == MOD_ALT)
        w_mod_n[{2'b10, w_evt.ext}] = !w_evt.brk;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_pcnt    <= '0;
      r_tmo     <= '0;
      r_seq_err <= 1'b0;
      r_ovf     <= 1'b0;
      r_mod     <= '0;
    end else begin
      r_state   <= w_state_n;
      r_pcnt    <= w_pcnt_n;
      r_seq_err <= w_err;
      r_mod     <= w_mod_n;
      if (w_push && w_full && !w_pop)
        r_ovf <= 1'b1;
      if (r_state == S_IDLE || received_data_en ||
          w_tmo_hit)
        r_tmo <= '0;
      else
        r_tmo <= r_tmo + 1'b1;
    end
  end

  ps2_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (EVT_W)
  ) u_fifo (
    .clk     (CLOCK_50),
    .rst     (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_evt),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign evt_valid = !w_empty;
  assign evt_code  = w_head.code;
  assign evt_ext   = w_head.ext;
  assign evt_break = w_head.brk;
  assign evt_mods  = w_head.mods;
  assign overflow  = r_ovf;
  assign seq_error = r_seq_err;

endmodule
